// File: rtl/dut_query_pkg.sv
// rtl/dut_query_pkg.sv - shared widths, state encoding and bus layout for the DUT query sequencer
package dut_query_pkg;

    localparam int PI_W_DEF  = 36;
    localparam int KEY_W_DEF = 15;
    localparam int PO_W_DEF  = 7;
    localparam int REP_W_DEF = 8;

    // Bit position of the key field inside the DUT input bus {key, pattern}.
    localparam int KEY_LSB = PI_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BASE  = 2'd1,
        APPLY = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dut_query_capture.sv
// rtl/dut_query_capture.sv - first-capture register and sticky mismatch compare on DUT outputs
// Optional 2-flop input synchronizer under DUT_QUERY_CAPTURE_SYNC_EN.
module dut_query_capture
    import dut_query_pkg::*;
#(
    parameter int W = PO_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         sample_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         mismatch_o
);

    logic [W-1:0] cap_data;
    logic [W-1:0] data_q;
    logic         mismatch_q;
    logic         have_first_q;

`ifdef DUT_QUERY_CAPTURE_SYNC_EN
    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
        end
    end

    assign cap_data = sync2_q;
`else
    assign cap_data = data_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            mismatch_q   <= 1'b0;
            have_first_q <= 1'b0;
        end else if (clear_i) begin
            mismatch_q   <= 1'b0;
            have_first_q <= 1'b0;
        end else if (sample_i) begin
            if (!have_first_q) begin
                data_q       <= cap_data;
                have_first_q <= 1'b1;
            end else if (cap_data != data_q) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign data_o     = data_q;
    assign mismatch_o = mismatch_q;

endmodule

// File: rtl/dut_query_sequencer.sv
// rtl/dut_query_sequencer.sv - baseline/apply/capture sequencer for the key-locked 51-in/7-out DUT
// DUT_QUERY_CAPTURE_SYNC_EN: synchronize DUT outputs and stretch APPLY by two cycles.
module dut_query_sequencer
    import dut_query_pkg::*;
#(
    parameter int PI_W   = PI_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int PO_W   = PO_W_DEF,
    parameter int SETTLE = 4,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_key_we,
    input  logic [KEY_W-1:0]      cfg_key,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PI_W-1:0]       req_pattern,
    input  logic [REP_W-1:0]      req_repeat,
    output logic [PI_W+KEY_W-1:0] dut_inputs,
    input  logic [PO_W-1:0]       dut_outputs,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PO_W-1:0]       rsp_data,
    output logic                  rsp_mismatch,
    output logic                  trig,
    output logic                  busy
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("dut_query_sequencer: SETTLE must be in 1..255");
    end

    localparam int CNT_W = 9;
`ifdef DUT_QUERY_CAPTURE_SYNC_EN
    localparam int APPLY_LEN = SETTLE + 2;
`else
    localparam int APPLY_LEN = SETTLE;
`endif
    localparam logic [CNT_W-1:0] BASE_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] APPLY_LOAD = CNT_W'(APPLY_LEN - 1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REP_W-1:0]     rem_q;
    logic [PI_W-1:0]      pattern_q;
    logic [PI_W-1:0]      pi_q;
    logic [KEY_W-1:0]     key_shadow_q;
    logic [KEY_W-1:0]     key_active_q;
    logic                 trig_q;
    logic                 busy_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;

    logic                 accept;
    logic                 sample;

    assign accept = (state_q == IDLE) && req_valid;
    assign sample = (state_q == APPLY) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            pattern_q    <= '0;
            pi_q         <= '0;
            key_shadow_q <= '0;
            key_active_q <= '0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
        end else begin
            // Shadow updates never race the active key: acceptance copies the old value.
            if (cfg_key_we) begin
                key_shadow_q <= cfg_key;
            end
            trig_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pattern_q    <= req_pattern;
                        rem_q        <= (req_repeat == '0) ? REP_W'(1) : req_repeat;
                        key_active_q <= key_shadow_q;
                        cnt_q        <= BASE_LOAD;
                        pi_q         <= '0;
                        state_q      <= BASE;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                BASE: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= APPLY_LOAD;
                        pi_q    <= pattern_q;
                        trig_q  <= 1'b1;
                        state_q <= APPLY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                APPLY: begin
                    if (cnt_q == '0) begin
                        rem_q <= rem_q - 1'b1;
                        pi_q  <= '0;
                        if (rem_q == REP_W'(1)) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            cnt_q   <= BASE_LOAD;
                            state_q <= BASE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dut_query_capture #(
        .W (PO_W)
    ) u_capture (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (accept),
        .sample_i   (sample),
        .data_i     (dut_outputs),
        .data_o     (rsp_data),
        .mismatch_o (rsp_mismatch)
    );

    assign dut_inputs = {key_active_q, pi_q};
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign trig       = trig_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dut_query_sequencer.sv
// tb/tb_dut_query_sequencer.sv - scoreboard bench for dut_query_sequencer with a key-locked DUT model
module tb_dut_query_sequencer;
    import dut_query_pkg::*;

    localparam int S   = 4;
    localparam int RW  = 8;
`ifdef DUT_QUERY_CAPTURE_SYNC_EN
    localparam int APL = S + 2;
`else
    localparam int APL = S;
`endif
    localparam int P = S + APL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_key_we = 1'b0;
    logic [14:0] cfg_key = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [35:0] req_pattern = '0;
    logic [7:0]  req_repeat = '0;
    logic [50:0] dut_inputs;
    logic [6:0]  dut_outputs;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [6:0]  rsp_data;
    logic        rsp_mismatch;
    logic        trig;
    logic        busy;

    always #5 clk = ~clk;

    dut_query_sequencer #(
        .PI_W(36), .KEY_W(15), .PO_W(7), .SETTLE(S), .REP_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_key_we(cfg_key_we), .cfg_key(cfg_key),
        .req_valid(req_valid), .req_ready(req_ready), .req_pattern(req_pattern),
        .req_repeat(req_repeat), .dut_inputs(dut_inputs), .dut_outputs(dut_outputs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mismatch(rsp_mismatch), .trig(trig), .busy(busy)
    );

    typedef struct packed {
        logic [6:0] data;
        logic       mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] tb_shadow = '0;
    logic        force_en = 1'b0;
    int          force_base = 0;
    int          trig_total;

    // Key-locked DUT stand-in: parity folding of all 51 inputs, key bits included.
    function automatic logic [6:0] model(input logic [50:0] x);
        logic [6:0] r;
        r = 7'h2B;
        for (int i = 0; i < 51; i++) r[i % 7] = r[i % 7] ^ x[i];
        if (x[50:KEY_LSB] != 15'h5A5A) r = ~r;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) trig_total <= 0;
        else if (trig) trig_total <= trig_total + 1;
    end

    always_comb begin
        dut_outputs = model(dut_inputs);
        if (force_en) dut_outputs = ((trig_total - force_base) <= 1) ? 7'h12 : 7'h13;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_query(input logic [35:0] pat, input int rep, input logic wr,
                             input logic [14:0] wr_key, input int hold, input logic frc,
                             input string tag);
        int n, pos, vcyc, ntrig, bad_sched, bad_trig, bad_hold;
        logic [14:0] kexp;
        logic [6:0] d0;
        exp_t e;
        n = (rep == 0) ? 1 : rep;
        wait_ready(tag);
        kexp = tb_shadow;
        force_en = frc;
        force_base = trig_total;
        e.data = frc ? 7'h12 : model({kexp, pat});
        e.mis = frc;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_pattern = pat;
        req_repeat = rep[7:0];
        cfg_key_we = wr;
        cfg_key = wr_key;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cfg_key_we = 1'b0;
        if (wr) tb_shadow = wr_key;
        vcyc = 0; ntrig = 0; bad_sched = 0; bad_trig = 0; bad_hold = 0;
        for (int k = 1; k <= n * P + 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                vcyc = k;
                break;
            end
            if (k <= n * P) begin
                pos = (k - 1) % P;
                if (dut_inputs[50:KEY_LSB] !== kexp) bad_sched++;
                if (dut_inputs[35:0] !== ((pos >= S) ? pat : 36'h0)) bad_sched++;
                if (trig !== (pos == S)) bad_trig++;
                if (trig === 1'b1) ntrig++;
            end
        end
        check_eq({tag, "_sched"}, 64'(bad_sched), 64'd0);
        check_eq({tag, "_trig_pos"}, 64'(bad_trig), 64'd0);
        check_eq({tag, "_trig_cnt"}, 64'(ntrig), 64'(n));
        check_eq({tag, "_latency"}, 64'(vcyc), 64'(n * P + 1));
        e = sb_q.pop_front();
        if (vcyc != 0) begin
            d0 = rsp_data;
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0 ||
                    busy !== 1'b1 || dut_inputs !== {kexp, 36'h0}) bad_hold++;
            end
            check_eq({tag, "_hold"}, 64'(bad_hold), 64'd0);
            check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.data));
            check_eq({tag, "_rsp_mis"}, 64'(rsp_mismatch), 64'(e.mis));
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check_eq({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
            check_eq({tag, "_post_ready"}, 64'(req_ready), 64'd1);
        end
        force_en = 1'b0;
    endtask

    task automatic write_key(input logic [14:0] k);
        cfg_key_we = 1'b1;
        cfg_key = k;
        @(posedge clk);
        #1;
        cfg_key_we = 1'b0;
        tb_shadow = k;
        @(negedge clk);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_dut_inputs", 64'(dut_inputs), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_rsp_mis", 64'(rsp_mismatch), 64'd0);
        check_eq("rst_trig", 64'(trig), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);

        write_key(15'h5A5A);
        run_query(36'h0_F0F0_F0F0, 1, 1'b0, 15'h0, 0, 1'b0, "basic");
        run_query(36'h1_2345_6789, 0, 1'b0, 15'h0, 0, 1'b0, "rep0");
        run_query(36'hA_5A5A_A5A5, 3, 1'b0, 15'h0, 0, 1'b0, "rep3");
        run_query(36'h3_0000_0001, 2, 1'b0, 15'h0, 0, 1'b1, "force");
        run_query(36'h0_0000_FFFF, 1, 1'b1, 15'h7FFF, 0, 1'b0, "keywr");
        run_query(36'hF_FFFF_FFFF, 1, 1'b0, 15'h0, 10, 1'b0, "keynew");

        wait_ready("rstmid");
        req_valid = 1'b1;
        req_pattern = 36'h9_8765_4321;
        req_repeat = 8'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (S + 1) @(negedge clk);
        check_eq("rstmid_trig", 64'(trig), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rstmid_dut_inputs", 64'(dut_inputs), 64'd0);
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_trig0", 64'(trig), 64'd0);
        check_eq("rstmid_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tb_shadow = 15'h0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_eq("rstmid_no_rsp", 64'(bad), 64'd0);

        run_query(36'h6_6666_0000, 1, 1'b0, 15'h0, 0, 1'b0, "post_rst_key0");
        write_key(15'h5A5A);
        run_query(36'h5_5555_5555, 255, 1'b0, 15'h0, 0, 1'b0, "rep255");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
